tdm_demux_4ch: RTL and testbench

Receive end of the 4-channel time-division link. The transmit side selects one of four channel words per beat with a 4:1 mux. This block takes the serial beat stream with its start-of-frame marker and distributes beats back into four held channel registers. It also tracks frame alignment, flags sync errors and pulses once per completed frame. It sits between the link input stage and the per-channel datapath consumers.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_dec.sv | 18 +
 rtl/tdm_demux_4ch.sv | 138 +++++++++++++
 tb/tb_tdm_demux_4ch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 4-channel TDM link receive side.
package tdm_pkg;

    localparam int unsigned NCH   = 4;
    localparam int unsigned SLOTW = 2;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

endpackage

// File: rtl/tdm_slot_dec.sv
// Slot-to-one-hot write-enable decoder, the receive-side counterpart of the
// transmit 4:1 channel select.
module tdm_slot_dec
    import tdm_pkg::*;
(
    input  logic [SLOTW-1:0] slot,
    input  logic             en,
    output logic [NCH-1:0]   we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[slot] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux_4ch.sv
// 4-channel TDM demultiplexer: frame alignment tracking, shadow capture of
// slots 0..2 and atomic update of all channel registers on the slot-3 beat.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_sof,
    input  logic [W-1:0]    in_data,
    output logic [W-1:0]    ch0_data,
    output logic [W-1:0]    ch1_data,
    output logic [W-1:0]    ch2_data,
    output logic [W-1:0]    ch3_data,
    output logic            frame_valid,
    output logic            locked,
    output logic            sync_err,
    output logic [ERRW-1:0] err_cnt
);

    state_t            state_q, state_d;
    logic [SLOTW-1:0]  slot_q, slot_d;
    logic [W-1:0]      shadow_q [NCH-1];
    logic [W-1:0]      shadow_d [NCH-1];
    logic [W-1:0]      ch_q [NCH];
    logic [W-1:0]      ch_d [NCH];
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;
    logic              locked_q, locked_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

    logic              wr_en;
    logic [SLOTW-1:0]  wr_slot;
    logic [NCH-1:0]    wr_we;

    tdm_slot_dec u_slot_dec (
        .slot (wr_slot),
        .en   (wr_en),
        .we   (wr_we)
    );

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        ch_d          = ch_q;
        err_cnt_d     = err_cnt_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        wr_en         = 1'b0;
        wr_slot       = slot_q;

        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        wr_en   = 1'b1;
                        wr_slot = '0;
                        slot_d  = SLOTW'(1);
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sof) begin
                        // SOF always opens a fresh frame; mid-frame it also flags the discard
                        wr_en      = 1'b1;
                        wr_slot    = '0;
                        slot_d     = SLOTW'(1);
                        sync_err_d = (slot_q != '0);
                    end else if (slot_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        wr_en  = 1'b1;
                        slot_d = slot_q + SLOTW'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        for (int unsigned i = 0; i < NCH - 1; i++) begin
            if (wr_we[i]) begin
                shadow_d[i] = in_data;
            end
        end

        // Last slot bypasses the shadow so the whole frame lands in one edge
        if (wr_we[NCH-1]) begin
            for (int unsigned i = 0; i < NCH - 1; i++) begin
                ch_d[i] = shadow_q[i];
            end
            ch_d[NCH-1]   = in_data;
            frame_valid_d = 1'b1;
        end

        if (sync_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRW'(1);
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            shadow_q      <= '{default: '0};
            ch_q          <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            ch_q          <= ch_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign ch0_data    = ch_q[0];
    assign ch1_data    = ch_q[1];
    assign ch2_data    = ch_q[2];
    assign ch3_data    = ch_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = locked_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Self-checking bench for tdm_demux_4ch: directed frames plus random beats
// against a queue-based frame model.
module tb_tdm_demux_4ch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = '0;
    logic [7:0] ch0_data, ch1_data, ch2_data, ch3_data;
    logic       frame_valid, locked, sync_err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_ch [4];
    bit         m_fv, m_se, m_locked;
    int         m_cnt;
    logic [7:0] m_q [$];

    tdm_demux_4ch #(.W(8), .ERRW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_data     (in_data),
        .ch0_data    (ch0_data),
        .ch1_data    (ch1_data),
        .ch2_data    (ch2_data),
        .ch3_data    (ch3_data),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ch0"}, 32'(ch0_data), 32'(m_ch[0]));
        chk({tag, ".ch1"}, 32'(ch1_data), 32'(m_ch[1]));
        chk({tag, ".ch2"}, 32'(ch2_data), 32'(m_ch[2]));
        chk({tag, ".ch3"}, 32'(ch3_data), 32'(m_ch[3]));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(m_se));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
    endtask

    task automatic model_err();
        m_se = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    // Frame-level model: an open frame is the queue of beats since its SOF.
    task automatic model_beat(input bit v, input bit sof, input logic [7:0] d);
        m_fv = 1'b0;
        m_se = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (sof) begin
                    m_q.delete();
                    m_q.push_back(d);
                    m_locked = 1'b1;
                end
            end else if (sof) begin
                if (m_q.size() != 0) model_err();
                m_q.delete();
                m_q.push_back(d);
            end else if (m_q.size() == 0) begin
                model_err();
                m_locked = 1'b0;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_ch[i] = m_q[i];
                    m_fv = 1'b1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        m_fv = 1'b0;
        m_se = 1'b0;
        m_locked = 1'b0;
        m_cnt = 0;
        m_q.delete();
    endtask

    task automatic beat(input bit v, input bit sof, input logic [7:0] d, input string tag);
        @(negedge clk);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        model_beat(v, sof, d);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b1, 8'($urandom), tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();

        // Reset state
        do_reset("reset");

        // Back-to-back frame
        beat(1, 1, 8'hAA, "f1.b0");
        beat(1, 0, 8'h11, "f1.b1");
        beat(1, 0, 8'h22, "f1.b2");
        beat(1, 0, 8'h33, "f1.b3");
        chk("tp1.ch0", 32'(ch0_data), 32'hAA);
        chk("tp1.ch3", 32'(ch3_data), 32'h33);
        chk("tp1.fv", 32'(frame_valid), 32'h1);
        chk("tp1.locked", 32'(locked), 32'h1);
        idle(1, "tp1.after");
        chk("tp1.fv_drop", 32'(frame_valid), 32'h0);

        // Spaced beats, then a second frame
        beat(1, 1, 8'hAA, "f2.b0"); idle(3, "f2.gap0");
        beat(1, 0, 8'h11, "f2.b1"); idle(3, "f2.gap1");
        beat(1, 0, 8'h22, "f2.b2"); idle(3, "f2.gap2");
        beat(1, 0, 8'h33, "f2.b3"); idle(3, "f2.gap3");
        beat(1, 1, 8'h01, "f3.b0");
        beat(1, 0, 8'h02, "f3.b1");
        beat(1, 0, 8'h03, "f3.b2");
        chk("tp2.hold_ch0", 32'(ch0_data), 32'hAA);
        beat(1, 0, 8'h04, "f3.b3");
        chk("tp2.new_ch2", 32'(ch2_data), 32'h03);

        // Early SOF
        beat(1, 1, 8'hAA, "es.b0");
        beat(1, 0, 8'h11, "es.b1");
        beat(1, 1, 8'h55, "es.sof");
        chk("tp3.sync_err", 32'(sync_err), 32'h1);
        chk("tp3.err_cnt", 32'(err_cnt), 32'h1);
        chk("tp3.no_fv", 32'(frame_valid), 32'h0);
        beat(1, 0, 8'h66, "es.b1n");
        beat(1, 0, 8'h77, "es.b2n");
        beat(1, 0, 8'h88, "es.b3n");
        chk("tp3.ch0", 32'(ch0_data), 32'h55);

        // Missing SOF while locked at slot 0
        beat(1, 0, 8'h99, "ms.beat");
        chk("tp4.locked", 32'(locked), 32'h0);
        chk("tp4.err_cnt", 32'(err_cnt), 32'h2);
        beat(1, 0, 8'h5A, "ms.drop0");
        beat(1, 0, 8'hA5, "ms.drop1");
        beat(1, 1, 8'hC0, "ms.r0");
        beat(1, 0, 8'hC1, "ms.r1");
        beat(1, 0, 8'hC2, "ms.r2");
        beat(1, 0, 8'hC3, "ms.r3");
        chk("tp4.relock_ch3", 32'(ch3_data), 32'hC3);

        // Pre-SOF beats and mid-frame reset
        do_reset("rst2");
        beat(1, 0, 8'h12, "pre.b0");
        beat(1, 0, 8'h34, "pre.b1");
        beat(1, 1, 8'hAA, "mr.b0");
        beat(1, 0, 8'h11, "mr.b1");
        do_reset("mr.reset");
        chk("tp5.locked", 32'(locked), 32'h0);
        beat(1, 0, 8'h22, "mr.b2");
        beat(1, 0, 8'h33, "mr.b3");

        // Error counter saturation via repeated missing-SOF violations
        for (int n = 0; n < 300; n++) begin
            beat(1, 1, 8'($urandom), "sat.b0");
            beat(1, 0, 8'($urandom), "sat.b1");
            beat(1, 0, 8'($urandom), "sat.b2");
            beat(1, 0, 8'($urandom), "sat.b3");
            beat(1, 0, 8'($urandom), "sat.miss");
        end
        chk("tp6.sat", 32'(err_cnt), 32'd255);
        beat(1, 1, 8'h01, "sat.more0");
        beat(1, 1, 8'h02, "sat.more1");
        chk("tp6.sat_hold", 32'(err_cnt), 32'd255);

        // Random beat stream
        do_reset("rnd.reset");
        for (int n = 0; n < 800; n++) begin
            beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                 8'($urandom), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
